// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its command driver.
// Contents: default widths, opcode encodings and the driver FSM state type.
package alu_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned OPW_DEF   = 2;

    localparam logic [OPW_DEF-1:0] OP_ADD = 2'b00;
    localparam logic [OPW_DEF-1:0] OP_SUB = 2'b01;
    localparam logic [OPW_DEF-1:0] OP_MUL = 2'b10;
    localparam logic [OPW_DEF-1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Command and result handshakes between a requester and alu_cmd_driver.
// Command side: cmd_valid/cmd_ready with cmd_op, cmd_a, cmd_b, cmd_use_acc.
// Result side:  res_valid/res_ready with res_data, res_err.
// Modports: slave = the driver block, master = the requester.
interface alu_cmd_driver_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned OPW   = OPW_DEF
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [OPW-1:0]   cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_use_acc;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, res_ready,
        output cmd_ready, res_valid, res_data, res_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, res_ready,
        input  cmd_ready, res_valid, res_data, res_err
    );

endinterface

// File: rtl/alu.sv
// Combinational 8-bit ALU: f = a op b, wrapping modulo 2^WIDTH.
// Ports: op (ADD/SUB/MUL/DIV), a, b in; f out.
// Division by zero returns all-ones so the output is never undefined.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned OPW   = OPW_DEF
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f
);

    always_comb begin
        f = '0;
        case (op)
            OPW'(OP_ADD): f = a + b;
            OPW'(OP_SUB): f = a - b;
            OPW'(OP_MUL): f = WIDTH'(a * b);
            default:      f = (b == '0) ? '1 : a / b;
        endcase
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Sequential initiator for the combinational ALU.
// Ports: clk, rst (async, active-high); bus (alu_cmd_driver_if.slave) carrying
// the command and result handshakes; alu_op/alu_a/alu_b registered ALU inputs;
// alu_f ALU result; acc accumulator holding the last successful result.
// A command is accepted in IDLE, issued to the ALU for one cycle, and its
// result is held in RESP until the consumer takes it. DIV by zero skips the
// ALU and returns res_err=1 with all-ones data.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned OPW   = OPW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_driver_if.slave  bus,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_f,
    output logic [WIDTH-1:0] acc
);

    state_t           state;
    state_t           state_n;
    logic             accept;
    logic             div_zero;
    logic [WIDTH-1:0] operand_a;

    assign div_zero  = (bus.cmd_op == OPW'(OP_DIV)) && (bus.cmd_b == '0);
    assign operand_a = bus.cmd_use_acc ? acc : bus.cmd_a;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_n = div_zero ? RESP : ISSUE;
                end
            end
            ISSUE:   state_n = RESP;
            RESP: begin
                if (bus.res_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs decoded from state; cmd_ready is held low while rst is asserted
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = ~rst;
                accept        = bus.cmd_valid;
            end
            RESP:    bus.res_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: ALU operand registers, result capture and accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op       <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            acc          <= '0;
            bus.res_data <= '0;
            bus.res_err  <= 1'b0;
        end else begin
            if (accept && div_zero) begin
                bus.res_err  <= 1'b1;
                bus.res_data <= '1;
            end else if (accept) begin
                alu_op      <= bus.cmd_op;
                alu_a       <= operand_a;
                alu_b       <= bus.cmd_b;
                bus.res_err <= 1'b0;
            end
            if (state == ISSUE) begin
                bus.res_data <= alu_f;
                acc          <= alu_f;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver looped through the combinational ALU.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_f;
    logic [7:0] acc;

    int checks = 0;
    int errors = 0;

    // Expected ALU-register and accumulator state tracked by the bench
    logic [1:0] m_op  = 2'd0;
    logic [7:0] m_a   = 8'd0;
    logic [7:0] m_b   = 8'd0;
    logic [7:0] m_acc = 8'd0;

    alu_cmd_driver_if #(.WIDTH(8), .OPW(2)) bus ();

    alu_cmd_driver #(.WIDTH(8), .OPW(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .alu_op(alu_op),
        .alu_a (alu_a),
        .alu_b (alu_b),
        .alu_f (alu_f),
        .acc   (acc)
    );

    alu #(.WIDTH(8), .OPW(2)) u_alu (
        .op(alu_op),
        .a (alu_a),
        .b (alu_b),
        .f (alu_f)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       use_acc;
        logic [7:0] exp_data;
        logic       exp_err;
        logic [7:0] exp_acc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("wait_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic check_alu_regs(input string tag);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'(m_op));
        chk({tag, "_alu_a"},  32'(alu_a),  32'(m_a));
        chk({tag, "_alu_b"},  32'(alu_b),  32'(m_b));
    endtask

    // One command through the full handshake with res_ready=1
    task automatic run_vec(input vec_t v);
        wait_ready();
        bus.cmd_op      = v.op;
        bus.cmd_a       = v.a;
        bus.cmd_b       = v.b;
        bus.cmd_use_acc = v.use_acc;
        bus.cmd_valid   = 1'b1;
        bus.res_ready   = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        if (!v.exp_err) begin
            m_op = v.op;
            m_a  = v.use_acc ? m_acc : v.a;
            m_b  = v.b;
            chk("issue_res_valid", 32'(bus.res_valid), 32'd0);
            chk("issue_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check_alu_regs("issue");
            step();
        end else begin
            check_alu_regs("err_hold");
        end
        chk("res_valid", 32'(bus.res_valid), 32'd1);
        chk("res_data",  32'(bus.res_data),  32'(v.exp_data));
        chk("res_err",   32'(bus.res_err),   32'(v.exp_err));
        chk("acc",       32'(acc),           32'(v.exp_acc));
        m_acc = v.exp_acc;
        step();
        chk("retire_res_valid", 32'(bus.res_valid), 32'd0);
        chk("retire_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    endtask

    logic [7:0] b2b_op [4];
    logic [7:0] b2b_a  [4];
    logic [7:0] b2b_b  [4];
    logic       b2b_ua [4];
    logic [7:0] b2b_exp[4];

    initial begin
        int acc_cyc[4];
        int k;
        int r;
        int cyc;
        logic acc_now;

        //        op      a      b     ua    data   err   acc
        vecs[0] = '{OP_ADD, 8'd200, 8'd100, 1'b0, 8'd44,  1'b0, 8'd44};
        vecs[1] = '{OP_SUB, 8'hA5,  8'd50,  1'b1, 8'd250, 1'b0, 8'd250};
        vecs[2] = '{OP_MUL, 8'h5A,  8'd3,   1'b1, 8'd238, 1'b0, 8'd238};
        vecs[3] = '{OP_DIV, 8'd200, 8'd7,   1'b0, 8'd28,  1'b0, 8'd28};
        vecs[4] = '{OP_DIV, 8'd9,   8'd0,   1'b0, 8'hFF,  1'b1, 8'd28};
        vecs[5] = '{OP_ADD, 8'h33,  8'd255, 1'b1, 8'd27,  1'b0, 8'd27};
        vecs[6] = '{OP_SUB, 8'd5,   8'd10,  1'b0, 8'd251, 1'b0, 8'd251};
        vecs[7] = '{OP_MUL, 8'd16,  8'd16,  1'b0, 8'd0,   1'b0, 8'd0};
        vecs[8] = '{OP_DIV, 8'h77,  8'd0,   1'b1, 8'hFF,  1'b1, 8'd0};
        vecs[9] = '{OP_DIV, 8'd255, 8'd255, 1'b0, 8'd1,   1'b0, 8'd1};

        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 2'd0;
        bus.cmd_a       = 8'd0;
        bus.cmd_b       = 8'd0;
        bus.cmd_use_acc = 1'b0;
        bus.res_ready   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data",  32'(bus.res_data),  32'd0);
        chk("rst_res_err",   32'(bus.res_err),   32'd0);
        chk("rst_acc",       32'(acc),           32'd0);
        check_alu_regs("rst");
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        step();

        // Table-driven commands
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Reset during ISSUE discards the command
        wait_ready();
        bus.cmd_op = OP_ADD; bus.cmd_a = 8'd1; bus.cmd_b = 8'd2;
        bus.cmd_use_acc = 1'b0; bus.cmd_valid = 1'b1; bus.res_ready = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        m_op = 2'd0; m_a = 8'd0; m_b = 8'd0; m_acc = 8'd0;
        chk("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("midrst_acc",       32'(acc),           32'd0);
        chk("midrst_res_data",  32'(bus.res_data),  32'd0);
        check_alu_regs("midrst");
        step();
        rst = 1'b0;
        #1;
        chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_no_stale", 32'(bus.res_valid), 32'd0);
        end
        chk("midrst_acc_kept", 32'(acc), 32'd0);

        // Backpressure: result held, new command not accepted
        wait_ready();
        bus.cmd_op = OP_ADD; bus.cmd_a = 8'd3; bus.cmd_b = 8'd4;
        bus.cmd_use_acc = 1'b0; bus.cmd_valid = 1'b1; bus.res_ready = 1'b0;
        step();
        m_op = OP_ADD; m_a = 8'd3; m_b = 8'd4;
        bus.cmd_op = OP_SUB; bus.cmd_a = 8'd1; bus.cmd_b = 8'd1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_res_data",  32'(bus.res_data),  32'd7);
            chk("bp_res_err",   32'(bus.res_err),   32'd0);
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check_alu_regs("bp");
            step();
        end
        bus.res_ready = 1'b1;
        bus.cmd_valid = 1'b0;
        step();
        chk("bp_release_res_valid", 32'(bus.res_valid), 32'd0);
        chk("bp_release_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("bp_acc", 32'(acc), 32'd7);
        check_alu_regs("bp_release");

        // Back-to-back with cmd_valid held high
        b2b_op[0] = 8'(OP_ADD); b2b_a[0] = 8'd10; b2b_b[0] = 8'd20; b2b_ua[0] = 1'b0; b2b_exp[0] = 8'd30;
        b2b_op[1] = 8'(OP_SUB); b2b_a[1] = 8'hEE; b2b_b[1] = 8'd5;  b2b_ua[1] = 1'b1; b2b_exp[1] = 8'd25;
        b2b_op[2] = 8'(OP_MUL); b2b_a[2] = 8'hEE; b2b_b[2] = 8'd4;  b2b_ua[2] = 1'b1; b2b_exp[2] = 8'd100;
        b2b_op[3] = 8'(OP_DIV); b2b_a[3] = 8'hEE; b2b_b[3] = 8'd7;  b2b_ua[3] = 1'b1; b2b_exp[3] = 8'd14;
        k = 0; r = 0; cyc = 0;
        bus.cmd_op = b2b_op[0][1:0]; bus.cmd_a = b2b_a[0];
        bus.cmd_b = b2b_b[0]; bus.cmd_use_acc = b2b_ua[0];
        bus.cmd_valid = 1'b1; bus.res_ready = 1'b1;
        while ((k < 4 || r < 4) && cyc < 40) begin
            if (bus.res_valid === 1'b1 && r < 4) begin
                chk("b2b_res_data", 32'(bus.res_data), 32'(b2b_exp[r]));
                chk("b2b_res_err",  32'(bus.res_err),  32'd0);
                r++;
            end
            acc_now = bus.cmd_valid && (bus.cmd_ready === 1'b1);
            step();
            cyc++;
            if (acc_now) begin
                acc_cyc[k] = cyc;
                k++;
                if (k < 4) begin
                    bus.cmd_op = b2b_op[k][1:0]; bus.cmd_a = b2b_a[k];
                    bus.cmd_b = b2b_b[k]; bus.cmd_use_acc = b2b_ua[k];
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
        end
        chk("b2b_accepted", 32'(k), 32'd4);
        chk("b2b_returned", 32'(r), 32'd4);
        for (int i = 1; i < 4; i++) begin
            if (i < k) chk("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        end
        chk("b2b_acc", 32'(acc), 32'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Sequential initiator for the combinational 8-bit ALU (inputs op, a, b; output f).
- Accepts commands over a valid/ready handshake and drives registered operands and opcode to the ALU.
- Captures f one cycle later and returns it over a valid/ready result handshake.
- Keeps an accumulator so results can chain into the next command, and blocks divide-by-zero before it reaches the ALU.

Parameters:
- WIDTH, 8, data width of operands, result and accumulator.
- OPW, 2, opcode width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  OPW  00=ADD, 01=SUB, 10=MUL, 11=DIV.
- cmd_a  in  WIDTH  immediate operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_use_acc  in  1  1: operand A is taken from the accumulator; cmd_a is ignored.
- alu_op  out  OPW  registered opcode to the ALU.
- alu_a  out  WIDTH  registered operand A to the ALU.
- alu_b  out  WIDTH  registered operand B to the ALU.
- alu_f  in  WIDTH  ALU result (combinational from alu_op, alu_a, alu_b).
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts the result.
- res_data  out  WIDTH  captured result.
- res_err  out  1  1 = command rejected (divide by zero).
- acc  out  WIDTH  current accumulator value.

Behaviour:
- Reset (async, active-high): state=IDLE; every output is 0 (cmd_ready=1 after reset deasserts, since it is decoded from IDLE). Asserting rst mid-operation discards the in-flight command; no result is produced for it.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, the command is accepted at that edge. Operand A is acc if cmd_use_acc=1, else cmd_a.
    - If op=DIV and B=0: load res_err=1, res_data=all-ones, go to RESP. The ALU outputs are not updated.
    - Otherwise: load alu_op, alu_a, alu_b; res_err=0; go to ISSUE.
  - ISSUE: exactly one cycle. At the closing edge, res_data<=alu_f and acc<=alu_f; go to RESP.
  - RESP: res_valid=1. res_data and res_err hold stable until res_ready=1 at an edge; then res_valid<=0 and go to IDLE.
- cmd_ready is 0 in ISSUE and RESP. There is no bypass: a command cannot be accepted in the same cycle a result retires.
- Latency, normal path: command accepted at edge N; ISSUE occupies cycle N..N+1; res_valid is high after edge N+1. Best-case throughput is one command per 3 cycles.
- Latency, error path: res_valid is high after edge N, with no ISSUE cycle.
- Arithmetic: all results are the WIDTH-bit ALU output, so ADD, SUB and MUL wrap modulo 2^WIDTH. DIV is unsigned truncating. The block performs no arithmetic itself.
- Accumulator: updated only on the ISSUE→RESP edge. It is unchanged by error commands and by reset-discarded commands.
- ALU outputs: alu_op, alu_a and alu_b hold their last issued values outside ISSUE.
- cmd_* inputs are sampled only at the accepting edge; changes at other times are ignored.
- res_ready while res_valid=0 has no effect.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV (OPW bits);
  - state enum IDLE/ISSUE/RESP;
  - WIDTH default.
- The same package is reused by the combinational ALU and by the benches.
- No sub-module is required inside the block: one FSM plus datapath registers.
- The testbench instantiates the combinational ALU and loops alu_op/alu_a/alu_b → alu_f.

Test Plan:
- Reset, then ADD a=200 b=100, use_acc=0, res_ready=1 → res_data=44, res_err=0, acc=44; res_valid high exactly 2 edges after acceptance.
- Chain: after acc=44, SUB use_acc=1 b=50 → res_data=250; then MUL use_acc=1 b=3 → res_data=238 (750 mod 256); acc tracks each result.
- DIV a=200 b=7 → res_data=28. Then DIV a=9 b=0 → res_err=1, res_data=8'hFF, res_valid one edge after acceptance, acc stays 28, ALU outputs unchanged.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid → res_valid, res_data and res_err stable, cmd_ready=0 throughout, and a new cmd_valid is not accepted. Release → res_valid drops next edge, cmd_ready=1.
- Reset mid-operation: assert rst during ISSUE → immediately res_valid=0, acc=0, alu_* outputs=0, cmd_ready=1 after release, and no stale result appears.
- Back-to-back: cmd_valid held high with 4 commands → each accepted only in IDLE, 3-cycle spacing; results are returned in order with correct values.
